// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and framing constants for the IMEM boot loader
package imem_loader_pkg;

  // CSUM is only reachable when IMEM_LOADER_CHECKSUM_EN is defined
  typedef enum logic [2:0] {
    HDR,
    DATA,
    CSUM,
    DONE,
    ERROR
  } loader_state_t;

  localparam int HDR_BYTES      = 4;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - assembles accepted stream bytes into little-endian 32-bit words
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        valid_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  // The first three bytes are parked in shift_q; the fourth is taken straight
  // from the stream so the full word is available in its handshake cycle.
  assign word_o       = {data_i, shift_q};
  assign word_valid_o = valid_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

  // Next-state: count accepted bytes (natural 3->0 wrap) and shift bytes in from the top
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clr_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (valid_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {data_i, shift_q[23:8]};
    end
  end

  // Counter and shift register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - streams a word-count-prefixed image into IMEM, then releases core reset (option: IMEM_LOADER_CHECKSUM_EN)
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int IMEM_WORDS = 1024,
  parameter int AW         = $clog2(IMEM_WORDS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  input  logic [7:0]      s_data,
  output logic            s_ready,
  input  logic            start,
  output logic            imem_we,
  output logic [AW-1:0]   imem_addr,
  output logic [XLEN-1:0] imem_wdata,
  output logic            cpu_rst_n,
  output logic            done,
  output logic            error,
  output logic [AW:0]     words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t END_STATE = CSUM;
`else
  localparam loader_state_t END_STATE = DONE;
`endif

  loader_state_t   state_q, state_d;
  logic [AW:0]     n_q, n_d;
  logic [AW:0]     words_loaded_q, words_loaded_d;
  logic            imem_we_q, imem_we_d;
  logic [AW-1:0]   imem_addr_q, imem_addr_d;
  logic [XLEN-1:0] imem_wdata_q, imem_wdata_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            cpu_rst_n_q, cpu_rst_n_d;

  logic            accept;
  logic            rearm;
  logic [31:0]     word;
  logic            word_valid;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  assign s_ready = (state_q == HDR) || (state_q == DATA) || (state_q == CSUM);
  assign accept  = s_valid && s_ready;
  assign rearm   = start && ((state_q == DONE) || (state_q == ERROR));

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (rearm),
    .valid_i      (accept),
    .data_i       (s_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  // Loader FSM: header decode, per-word IMEM strobe, and registered reset release
  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    words_loaded_d = words_loaded_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    done_d         = done_q;
    error_d        = error_q;
    cpu_rst_n_d    = cpu_rst_n_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d         = csum_q;
    if (accept && ((state_q == HDR) || (state_q == DATA))) begin
      csum_d = csum_q ^ s_data;
    end
`endif
    case (state_q)
      HDR: begin
        if (word_valid) begin
          if (word > XLEN'(IMEM_WORDS)) begin
            state_d = ERROR;
            error_d = 1'b1;
          end else if (word == '0) begin
            state_d = END_STATE;
          end else begin
            state_d = DATA;
            n_d     = word[AW:0];
          end
        end
      end
      DATA: begin
        if (word_valid) begin
          imem_we_d      = 1'b1;
          imem_addr_d    = words_loaded_q[AW-1:0];
          imem_wdata_d   = word;
          words_loaded_d = words_loaded_q + 1'b1;
          // Leave DATA on the final handshake so s_ready drops before any extra byte
          if ((words_loaded_q + 1'b1) == n_q) begin
            state_d = END_STATE;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          if (s_data == csum_q) begin
            state_d = DONE;
          end else begin
            state_d = ERROR;
            error_d = 1'b1;
          end
        end
      end
`endif
      DONE: begin
        if (start) begin
          state_d        = HDR;
          done_d         = 1'b0;
          cpu_rst_n_d    = 1'b0;
          words_loaded_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d         = '0;
`endif
        end else begin
          // One cycle behind state entry, so the last write lands before release
          done_d      = 1'b1;
          cpu_rst_n_d = 1'b1;
        end
      end
      ERROR: begin
        if (start) begin
          state_d        = HDR;
          error_d        = 1'b0;
          cpu_rst_n_d    = 1'b0;
          words_loaded_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d         = '0;
`endif
        end
      end
      default: begin
        state_d = HDR;
      end
    endcase
  end

  // State and output registers, all cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= HDR;
      n_q            <= '0;
      words_loaded_q <= '0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      cpu_rst_n_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      words_loaded_q <= words_loaded_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      done_q         <= done_d;
      error_q        <= error_d;
      cpu_rst_n_q    <= cpu_rst_n_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR over header and data bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign done         = done_q;
  assign error        = error_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time program loader sitting directly upstream of riscv_pipelined.
- Accepts a little-endian byte stream: a 4-byte header holding the word count N, then N 32-bit instruction words.
- Writes each assembled word into the core's instruction memory write port.
- Holds the core in reset (cpu_rst_n low) until the image is fully written, then releases it so the core fetches from PC 0.

Parameters:
- XLEN, 32: instruction/data word width; only 32 is supported.
- IMEM_WORDS, 1024: instruction memory depth in words; must match the core's IMEM_WORDS.
- AW, $clog2(IMEM_WORDS): word address width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  byte stream valid.
- s_data  in  8  byte stream data.
- s_ready  out  1  loader can accept a byte.
- start  in  1  one-cycle pulse; re-arms the loader from DONE or ERROR.
- imem_we  out  1  IMEM write strobe, one cycle per word.
- imem_addr  out  AW  IMEM word address.
- imem_wdata  out  32  IMEM write data.
- cpu_rst_n  out  1  active-low reset to the core; low while loading.
- done  out  1  image loaded; core running.
- error  out  1  load aborted.
- words_loaded  out  AW+1  count of words written so far.

Behaviour:
- Reset values:
  - State HDR, s_ready=1.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_rst_n=0, done=0, error=0, words_loaded=0.
- Handshake:
  - A byte transfers on a rising edge where s_valid && s_ready.
  - s_ready is a function of state only: 1 in HDR, DATA and CSUM; 0 in DONE and ERROR.
  - Gaps in s_valid are legal and stall the loader with no side effects.
- Byte assembly:
  - A 2-bit byte counter counts accepted bytes and wraps 3->0.
  - Byte k of a word lands in bits [8k+7:8k] (little-endian).
- States and transitions:
  - HDR: accumulates the header word. After the 4th byte:
    - N > IMEM_WORDS -> ERROR.
    - N == 0 -> DONE (or CSUM if the feature is compiled in).
    - otherwise -> DATA.
  - DATA: on the 4th byte of each word, the cycle after the handshake:
    - imem_we=1 for exactly one cycle, imem_addr=words_loaded[AW-1:0], imem_wdata=assembled word.
    - words_loaded increments in the same cycle as the strobe.
    - When words_loaded reaches N -> DONE (or CSUM).
  - DONE: done=1 and cpu_rst_n=1, both registered. They rise in the cycle after the final imem_we or after the header, so the last IMEM write precedes reset release by at least one cycle.
  - ERROR: error=1; cpu_rst_n stays 0.
- start:
  - In DONE or ERROR: next cycle goes to HDR; clears done, error, words_loaded and the byte counter; drives cpu_rst_n=0.
  - Ignored in HDR, DATA and CSUM.
- Header value: N is 32 bits, compared unsigned. N=IMEM_WORDS is legal and fills memory exactly; the last write is at address IMEM_WORDS-1.
- rst asserted mid-load: all state clears immediately (asynchronously) and cpu_rst_n drops to 0. Partially written IMEM contents are not cleared.
- No imem_we is ever issued in HDR, DONE, ERROR or CSUM.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR covers every accepted header and data byte.
  - After the last data word (or a zero-count header), state CSUM accepts exactly one trailer byte.
  - Trailer equals the running XOR -> DONE; otherwise -> ERROR.
  - The running XOR clears on rst and on start.
- Undefined: the CSUM state, the XOR register and the trailer byte do not exist. The stream ends after the last data word.

Decomposition:
- Package imem_loader_pkg:
  - State enum loader_state_t {HDR, DATA, CSUM, DONE, ERROR}.
  - Constant HDR_BYTES=4.
  - Constant BYTES_PER_WORD=4.
- Sub-module byte_packer: 2-bit counter plus 32-bit shift assembly.
  - Outputs word and word_valid; word_valid is a one-cycle pulse on the 4th accepted byte.
  - Has a synchronous clear input driven by start.
- FSM, address counter and reset-release logic stay in imem_boot_loader.

Test Plan:
- Two-word load: stream 02 00 00 00, 13 00 10 00, 93 00 20 00 with s_valid held high.
  - Expect imem_we at addr 0 = 0x00100013, then addr 1 = 0x00200093.
  - Then done=1 and cpu_rst_n=1 one cycle after the 2nd write; words_loaded=2.
- Backpressure: same image with s_valid toggling every other cycle.
  - Expect identical writes and contents; no write ever issued on a stall cycle.
- Zero and overflow headers:
  - Header 0x00000000 -> DONE with no imem_we.
  - Header 0x00000401 with IMEM_WORDS=1024 -> error=1, s_ready=0, cpu_rst_n stays 0.
- Reset mid-load: assert rst after the 2nd byte of data word 1.
  - Expect all outputs at reset values asynchronously.
  - A fresh two-word stream then loads correctly from addr 0.
- Re-arm: pulse start in DONE.
  - Expect cpu_rst_n=0 and s_ready=1 next cycle.
  - A new 1-word image (0x00000073) is written at addr 0 and the loader returns to DONE.
- Checksum (IMEM_LOADER_CHECKSUM_EN defined): header 01 00 00 00, word 13 00 00 00.
  - Trailer 0x12 -> DONE.
  - Trailer 0x13 -> ERROR, cpu_rst_n stays 0.
